io_input_filter: RTL

- Receive-side companion to the pad output and tristate buffers: conditions WIDTH asynchronous pad inputs (after input buffering) for the core clock domain.
- Per channel: multi-flop synchronizer, then a stable-count glitch filter, then edge detection with sticky, maskable event flags.
- Output is a combined interrupt line for GPIO and similar peripherals.

---
 rtl/io_input_filter.sv | 88 ++++++++
 1 files changed

// File: rtl/io_input_filter.sv
// Per-channel pad input conditioning: synchronizer, stable-count glitch filter,
// edge pulses and sticky maskable event flags with a combined interrupt.
module io_input_filter #(
  parameter int                 WIDTH         = 8,
  parameter int                 SYNC_STAGES   = 2,
  parameter int                 FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE   = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PAD_I,
  input  logic [WIDTH-1:0] RISE_EN,
  input  logic [WIDTH-1:0] FALL_EN,
  input  logic [WIDTH-1:0] EVT_CLR,
  output logic [WIDTH-1:0] VALUE,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] PENDING,
  output logic             IRQ
);

  localparam int             CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [CW-1:0]                     cnt_q [WIDTH];
  logic [CW-1:0]                     cnt_d [WIDTH];
  logic [WIDTH-1:0]                  value_q, value_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [WIDTH-1:0]                  pending_q, pending_d;
  logic [WIDTH-1:0]                  sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Next-state logic: synchronizer shift, filter counters, edges and sticky flags
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], PAD_I};
    value_d = value_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync_s[i] == value_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        // Count complete: follow the synchronized level and restart
        value_d[i] = sync_s[i];
        cnt_d[i]   = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    rise_d    = value_d & ~value_q;
    fall_d    = ~value_d & value_q;
    pending_d = (pending_q & ~EVT_CLR) | (rise_d & RISE_EN) | (fall_d & FALL_EN);
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q    <= {SYNC_STAGES{RESET_VALUE}};
      value_q   <= RESET_VALUE;
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      pending_q <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync_q    <= sync_d;
      value_q   <= value_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign VALUE   = value_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;
  assign PENDING = pending_q;
  assign IRQ     = |pending_q;

endmodule
